// File: rtl/key_debounce.sv
// key_debounce: strobe-sampled per-key debouncer with press/release pulses.
// Optional auto-repeat of key_press while held is enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce #(
  parameter int N_KEYS        = 8,
  parameter int STABLE_CNT    = 3,
  parameter int REPEAT_DELAY  = 25,
  parameter int REPEAT_PERIOD = 5
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              tick,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);
  if (STABLE_CNT < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
    $error("key_debounce: illegal parameter combination");
  end
  logic              tick_m, tick_s, tick_d, strobe;
  logic [N_KEYS-1:0] key_m, key_s, acc;
  logic [CW-1:0]     cnt [N_KEYS];
`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RLOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [RW-1:0] rep [N_KEYS];
`endif
  assign strobe = tick_s & ~tick_d;
  for (genvar k = 0; k < N_KEYS; k++) begin : g_acc
    assign acc[k] = strobe && (key_s[k] != key_level[k]) && (cnt[k] == CMAX);
  end
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      tick_m      <= 1'b0;
      tick_s      <= 1'b0;
      tick_d      <= 1'b0;
      key_m       <= '0;
      key_s       <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        cnt[i] <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rep[i] <= '0;
`endif
      end
    end else begin
      tick_m      <= tick;
      tick_s      <= tick_m;
      tick_d      <= tick_s;
      key_m       <= key_in;
      key_s       <= key_m;
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (strobe) begin
          if (key_s[i] == key_level[i]) cnt[i] <= '0;
          else if (acc[i]) begin
            cnt[i]         <= '0;
            key_level[i]   <= key_s[i];
            key_press[i]   <= key_s[i];
            key_release[i] <= ~key_s[i];
          end else cnt[i] <= cnt[i] + 1'b1;
        end
`ifdef KEY_AUTOREPEAT_EN
        // the accepting release strobe must not also emit a repeat
        if (!key_level[i]) rep[i] <= '0;
        else if (strobe && !acc[i]) begin
          if (rep[i] == RMAX) begin
            rep[i]       <= RLOAD;
            key_press[i] <= 1'b1;
          end else rep[i] <= rep[i] + 1'b1;
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed tables, hand sequences and random stimulus for key_debounce,
// checked against a strobe-level behavioural model; honours KEY_AUTOREPEAT_EN.
module tb_key_debounce;
  localparam int N  = 8;
  localparam int SC = 3;
  localparam int RD = 4;
  localparam int RP = 2;

  logic         clkin, rst, tick;
  logic [N-1:0] key_in, key_level, key_press, key_release;

  key_debounce #(.N_KEYS(N), .STABLE_CNT(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clkin(clkin), .rst(rst), .tick(tick), .key_in(key_in),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  initial begin
    tick = 1'b0;
    forever begin
      repeat (5) @(posedge clkin);
      #2 tick = ~tick;
    end
  end

  logic [N-1:0] m_level, m_press, m_release, ks, kh0, kh1, kh2;
  logic [2:0]   tph;
  logic         stb, was, acc;
  int           run [N];
`ifdef KEY_AUTOREPEAT_EN
  int           held [N];
`endif

  // model: pins seen two edges late; each strobe applies the run-length acceptance rule
  initial begin
    forever begin
      @(posedge clkin or posedge rst);
      if (rst) begin
        tph = '0; kh0 = '0; kh1 = '0; kh2 = '0;
        m_level = '0; m_press = '0; m_release = '0;
        for (int i = 0; i < N; i++) begin
          run[i] = 0;
`ifdef KEY_AUTOREPEAT_EN
          held[i] = 0;
`endif
        end
      end else begin
        stb = tph[1] & ~tph[2];
        ks = kh1;
        m_press = '0;
        m_release = '0;
        if (stb) begin
          for (int i = 0; i < N; i++) begin
            was = m_level[i];
            acc = 1'b0;
            if (ks[i] == was) run[i] = 0;
            else if (run[i] + 1 >= SC) begin
              acc = 1'b1;
              run[i] = 0;
              m_level[i] = ks[i];
              m_press[i] = ks[i];
              m_release[i] = ~ks[i];
            end else run[i] = run[i] + 1;
`ifdef KEY_AUTOREPEAT_EN
            if (was && !acc) begin
              held[i] = held[i] + 1;
              if (held[i] >= RD && (held[i] - RD) % RP == 0) m_press[i] = 1'b1;
            end
`endif
          end
        end
`ifdef KEY_AUTOREPEAT_EN
        for (int i = 0; i < N; i++) if (!m_level[i]) held[i] = 0;
`endif
        tph = {tph[1:0], tick};
        kh2 = kh1; kh1 = kh0; kh0 = key_in;
      end
    end
  end

  int checks, failures, strobes_seen, combos;
  int pc [N];
  int rc [N];
  logic tick_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clkin);
    check("model_level", 32'(key_level), 32'(m_level));
    check("model_press", 32'(key_press), 32'(m_press));
    check("model_release", 32'(key_release), 32'(m_release));
    for (int i = 0; i < N; i++) begin
      pc[i] += int'(key_press[i]);
      rc[i] += int'(key_release[i]);
    end
    if (key_press == 8'h24 && key_release == 8'h01) combos++;
    if (tick && !tick_prev) strobes_seen++;
    tick_prev = tick;
  endtask

  task automatic wait_strobes(input int n);
    int target;
    target = strobes_seen + n;
    while (strobes_seen < target) step();
    repeat (4) step();
  endtask

  typedef struct {
    logic [N-1:0] keys;
    int           n;
    logic [N-1:0] exp;
  } vec_t;
  vec_t tbl [8];

  int sp [N];
  int sr [N];
  int sc, exp_rep;

  task automatic snap();
    for (int i = 0; i < N; i++) begin
      sp[i] = pc[i];
      sr[i] = rc[i];
    end
    sc = combos;
  endtask

  initial begin
    checks = 0; failures = 0; strobes_seen = 0; combos = 0; tick_prev = 1'b0;
    for (int i = 0; i < N; i++) begin pc[i] = 0; rc[i] = 0; end
    tbl[0] = '{8'h00, 3, 8'h00};
    tbl[1] = '{8'hA5, 2, 8'h00};
    tbl[2] = '{8'h00, 1, 8'h00};
    tbl[3] = '{8'hA5, 2, 8'h00};
    tbl[4] = '{8'hA5, 1, 8'hA5};
    tbl[5] = '{8'h5A, 3, 8'h5A};
    tbl[6] = '{8'hFF, 2, 8'h5A};
    tbl[7] = '{8'h5A, 1, 8'h5A};

    // reset held with all keys down and tick running
    rst = 1'b1; key_in = 8'hFF;
    repeat (30) begin
      step();
      check("reset_quiet", 32'({key_level, key_press, key_release}), 32'h0);
    end
    while (tick) step();
    #2 rst = 1'b0;
    snap();
    wait_strobes(2);
    check("rel_level_2strobes", 32'(key_level), 32'h00);
    wait_strobes(1);
    check("rel_level_3strobes", 32'(key_level), 32'hFF);
    for (int i = 0; i < N; i++) check("rel_press_once", 32'(pc[i] - sp[i]), 32'd1);

    key_in = 8'h00;
    wait_strobes(3);
    check("all_released", 32'(key_level), 32'h00);

    // single key press accepted on the third strobe
    key_in = 8'h01;
    snap();
    wait_strobes(2);
    check("k0_not_yet", 32'(key_level[0]), 32'd0);
    wait_strobes(1);
    check("k0_level", 32'(key_level[0]), 32'd1);
    check("k0_press_once", 32'(pc[0] - sp[0]), 32'd1);
    check("k0_no_release", 32'(rc[0] - sr[0]), 32'd0);

    // two-strobe glitch on key 1
    key_in = 8'h03;
    snap();
    wait_strobes(2);
    key_in = 8'h01;
    wait_strobes(3);
    check("k1_glitch_level", 32'(key_level), 32'h01);
    check("k1_glitch_press", 32'(pc[1] - sp[1]), 32'd0);
    check("k1_glitch_release", 32'(rc[1] - sr[1]), 32'd0);

    for (int v = 0; v < 8; v++) begin
      key_in = tbl[v].keys;
      wait_strobes(tbl[v].n);
      check($sformatf("table_%0d", v), 32'(key_level), 32'(tbl[v].exp));
    end

    key_in = 8'hC3;
    wait_strobes(3);
    check("pre_combo", 32'(key_level), 32'hC3);
    // keys 2,5 rise while key 0 falls
    key_in = 8'hE6;
    snap();
    wait_strobes(3);
    check("combo_seen", 32'(combos - sc), 32'd1);
    check("combo_level", 32'(key_level), 32'hE6);

    // reset pulse mid-hold
    @(negedge tick);
    repeat (2) step();
    snap();
    #2 rst = 1'b1;
    #1;
    check("rst_level_clear", 32'(key_level), 32'h00);
    check("rst_no_release", 32'(key_release), 32'h00);
    step();
    #2 rst = 1'b0;
    wait_strobes(2);
    check("rst_requal_wait", 32'(key_level), 32'h00);
    wait_strobes(1);
    check("rst_requal_level", 32'(key_level), 32'hE6);
    check("rst_repress", 32'(pc[6] - sp[6]), 32'd1);
    check("rst_no_rel_pulse", 32'(rc[1] - sr[1] + rc[2] - sr[2] + rc[6] - sr[6]), 32'd0);

    // held key: auto-repeat when enabled, single press otherwise
    key_in = 8'h00;
    wait_strobes(3);
    key_in = 8'h08;
    snap();
    wait_strobes(3);
    wait_strobes(9);
`ifdef KEY_AUTOREPEAT_EN
    exp_rep = 4;
`else
    exp_rep = 1;
`endif
    check("hold_presses", 32'(pc[3] - sp[3]), 32'(exp_rep));
    key_in = 8'h00;
    wait_strobes(3);
    check("hold_release", 32'(rc[3] - sr[3]), 32'd1);
    snap();
    wait_strobes(6);
    check("after_release_quiet", 32'(pc[3] - sp[3]), 32'd0);

    // random keys, occasional async reset
    for (int c = 0; c < 4000; c++) begin
      step();
      if ($urandom_range(0, 11) == 0) key_in = key_in ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 699) == 0) begin
        #2 rst = 1'b1;
        step();
        #2 rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
